// File: rtl/wb_sram_pkg.sv
// Shared types and geometry for the 512x32 Wishbone SRAM controller.
package wb_sram_pkg;
   localparam int RAM_AW    = 9;
   localparam int RAM_DW    = 32;
   localparam int RAM_BYTES = 4;
   localparam logic [RAM_AW-1:0] INIT_LAST = 9'd511;

   typedef enum logic [1:0] {
      ST_CLEAR  = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_ACK    = 2'd3
   } state_t;
endpackage

// File: rtl/wb_sram_init_seq.sv
// Post-reset clear sequencer: walks every word address once, then latches done.
module wb_sram_init_seq
   import wb_sram_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   output logic [RAM_AW-1:0] cnt_o,
   output logic              last_o,
   output logic              done_o
);

   logic [RAM_AW-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;

   always_comb begin
      cnt_d  = cnt_q;
      done_d = done_q;
      if (en_i && !done_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == INIT_LAST) done_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == INIT_LAST);
   assign done_o = done_q;

endmodule

// File: rtl/wb_sram_512x32_ctrl.sv
// Wishbone classic slave for a 512x32 synchronous SRAM with byte writes; one transfer per 3 cycles.
// Define WB_SRAM_INIT_CLEAR_EN to zero the whole array after reset before bus requests are accepted.
module wb_sram_512x32_ctrl
   import wb_sram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic                 wb_we_i,
   input  logic [RAM_BYTES-1:0] wb_sel_i,
   input  logic [31:0]          wb_adr_i,
   input  logic [RAM_DW-1:0]    wb_dat_i,
   output logic [RAM_DW-1:0]    wb_dat_o,
   output logic                 wb_ack_o,
   output logic                 ram_cen,
   output logic                 ram_gwen,
   output logic [RAM_BYTES-1:0] ram_wen,
   output logic [RAM_AW-1:0]    ram_a,
   output logic [RAM_DW-1:0]    ram_d,
   input  logic [RAM_DW-1:0]    ram_q,
   output logic                 init_done_o
);

`ifdef WB_SRAM_INIT_CLEAR_EN
   localparam state_t RST_STATE = ST_CLEAR;
`else
   localparam state_t RST_STATE = ST_IDLE;
`endif

   state_t                 state_q, state_d;
   logic                   cen_q, cen_d, gwen_q, gwen_d, ack_q, ack_d, rd_q, rd_d;
   logic [RAM_BYTES-1:0]   wen_q, wen_d;
   logic [RAM_AW-1:0]      a_q, a_d;
   logic [RAM_DW-1:0]      d_q, d_d;
   logic                   req;
   logic                   unused_adr;

   assign req        = wb_cyc_i & wb_stb_i & (wb_adr_i[31:11] == BASE_ADDR[31:11]);
   assign unused_adr = ^wb_adr_i[1:0];

`ifdef WB_SRAM_INIT_CLEAR_EN
   logic [RAM_AW-1:0] clr_cnt;
   logic              clr_last, clr_done;

   wb_sram_init_seq u_init_seq (
      .clk_i  (CLK),
      .rst_i  (RST),
      .en_i   (state_q == ST_CLEAR),
      .cnt_o  (clr_cnt),
      .last_o (clr_last),
      .done_o (clr_done)
   );

   assign init_done_o = clr_done;
`else
   assign init_done_o = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      cen_d   = cen_q;
      gwen_d  = gwen_q;
      wen_d   = wen_q;
      a_d     = a_q;
      d_d     = d_q;
      rd_d    = rd_q;
      ack_d   = 1'b0;
      case (state_q)
`ifdef WB_SRAM_INIT_CLEAR_EN
         ST_CLEAR: begin
            // The final word is still driven for one cycle after leaving CLEAR.
            cen_d  = 1'b0;
            gwen_d = 1'b0;
            wen_d  = '0;
            a_d    = clr_cnt;
            d_d    = '0;
            if (clr_last) state_d = ST_IDLE;
         end
`endif
         ST_IDLE: begin
            cen_d  = 1'b1;
            gwen_d = 1'b1;
            wen_d  = '1;
            if (req) begin
               state_d = ST_ACCESS;
               a_d     = wb_adr_i[10:2];
               d_d     = wb_dat_i;
               cen_d   = 1'b0;
               gwen_d  = ~wb_we_i;
               wen_d   = wb_we_i ? ~wb_sel_i : '1;
               rd_d    = ~wb_we_i;
            end
         end
         ST_ACCESS: begin
            // The SRAM commits this edge regardless; only the ack depends on the master.
            cen_d   = 1'b1;
            gwen_d  = 1'b1;
            wen_d   = '1;
            ack_d   = wb_cyc_i;
            state_d = wb_cyc_i ? ST_ACK : ST_IDLE;
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= RST_STATE;
         cen_q   <= 1'b1;
         gwen_q  <= 1'b1;
         wen_q   <= '1;
         a_q     <= '0;
         d_q     <= '0;
         ack_q   <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cen_q   <= cen_d;
         gwen_q  <= gwen_d;
         wen_q   <= wen_d;
         a_q     <= a_d;
         d_q     <= d_d;
         ack_q   <= ack_d;
         rd_q    <= rd_d;
      end
   end

   assign ram_cen  = cen_q;
   assign ram_gwen = gwen_q;
   assign ram_wen  = wen_q;
   assign ram_a    = a_q;
   assign ram_d    = d_q;
   assign wb_ack_o = ack_q;
   assign wb_dat_o = (ack_q && rd_q) ? ram_q : '0;

endmodule

// File: tb/tb_wb_sram_512x32_ctrl.sv
// Bench for wb_sram_512x32_ctrl: behavioural SRAM, directed Wishbone transfers, ack-driven scoreboard.
module tb_wb_sram_512x32_ctrl;
   logic        CLK = 1'b0;
   logic        RST;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic        wb_ack_o;
   logic        ram_cen, ram_gwen;
   logic [3:0]  ram_wen;
   logic [8:0]  ram_a;
   logic [31:0] ram_d, ram_q;
   logic        init_done_o;

   logic [31:0] mem [0:511];
   logic [31:0] exp_q [$];
   int          compared = 0;
   int          mismatched = 0;

   always #5 CLK = ~CLK;

   wb_sram_512x32_ctrl #(.BASE_ADDR(32'h0000_0000)) dut (
      .CLK(CLK), .RST(RST),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen),
      .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q),
      .init_done_o(init_done_o)
   );

   always @(posedge CLK) begin : sram
      logic [31:0] w;
      if (!ram_cen) begin
         w = mem[ram_a];
         for (int b = 0; b < 4; b++)
            if (!ram_wen[b]) w[8*b +: 8] = ram_d[8*b +: 8];
         if (!ram_gwen) mem[ram_a] <= w;
         ram_q <= mem[ram_a];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (RST === 1'b0 && wb_ack_o === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_ack", {31'h0, wb_ack_o}, 32'h0);
         else                   chk("ack_data", wb_dat_o, exp_q.pop_front());
      end
   end

   task automatic drive(input logic w, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w;
      wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
   endtask

   task automatic idle_bus();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic xfer(input logic w, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input logic [31:0] exp_rd, input int exp_lat, input int limit);
      int lat;
      bit got;
      @(negedge CLK);
      drive(w, adr, sel, dat);
      exp_q.push_back(w ? 32'h0 : exp_rd);
      lat = 0;
      got = 1'b0;
      while (!got && lat < limit) begin
         @(negedge CLK);
         lat++;
         if (wb_ack_o) got = 1'b1;
      end
      idle_bus();
      if (!got) begin
         chk("ack_timeout", {31'h0, wb_ack_o}, 32'h1);
         if (exp_q.size() > 0) void'(exp_q.pop_back());
      end else begin
         chk("ack_latency", 32'(lat), 32'(exp_lat));
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!init_done_o && n < 700) begin
         @(negedge CLK);
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cen_lows, acks;
      logic [31:0] exp_30;
      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      ram_q = 32'h0;
      idle_bus();
      wb_sel_i = 4'h0; wb_adr_i = 32'h0; wb_dat_i = 32'h0;
      RST = 1'b1;

      // Reset state
      @(negedge CLK);
      chk("rst_cen",  {31'h0, ram_cen}, 32'h1);
      chk("rst_gwen", {31'h0, ram_gwen}, 32'h1);
      chk("rst_wen",  {28'h0, ram_wen}, 32'hF);
      chk("rst_a",    {23'h0, ram_a}, 32'h0);
      chk("rst_d",    ram_d, 32'h0);
      chk("rst_ack",  {31'h0, wb_ack_o}, 32'h0);
      chk("rst_dat",  wb_dat_o, 32'h0);
`ifdef WB_SRAM_INIT_CLEAR_EN
      chk("rst_init_done", {31'h0, init_done_o}, 32'h0);
`else
      chk("rst_init_done", {31'h0, init_done_o}, 32'h1);
`endif
      @(negedge CLK);
      RST = 1'b0;
`ifdef WB_SRAM_INIT_CLEAR_EN
      wait_done(n);
      chk("init_time", 32'(n), 32'd512);
`endif

      // Write with SRAM pin checks, then read back
      @(negedge CLK);
      drive(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
      exp_q.push_back(32'h0);
      @(negedge CLK);
      chk("wr_cen",  {31'h0, ram_cen}, 32'h0);
      chk("wr_a",    {23'h0, ram_a}, 32'h4);
      chk("wr_gwen", {31'h0, ram_gwen}, 32'h0);
      chk("wr_wen",  {28'h0, ram_wen}, 32'h0);
      chk("wr_d",    ram_d, 32'hDEAD_BEEF);
      chk("wr_ack_early", {31'h0, wb_ack_o}, 32'h0);
      @(negedge CLK);
      chk("wr_ack", {31'h0, wb_ack_o}, 32'h1);
      chk("wr_cen_release", {31'h0, ram_cen}, 32'h1);
      idle_bus();
      xfer(1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 2, 10);
      xfer(1'b0, 32'h0000_0013, 4'h0, 32'h0, 32'hDEAD_BEEF, 2, 10);

      // Byte-lane merge and empty select
      xfer(1'b1, 32'h0000_0040, 4'hF, 32'h1122_3344, 32'h0, 2, 10);
      xfer(1'b1, 32'h0000_0040, 4'b0101, 32'hAABB_CCDD, 32'h0, 2, 10);
      xfer(1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'h11BB_33DD, 2, 10);
      xfer(1'b1, 32'h0000_0040, 4'h0, 32'hFFFF_FFFF, 32'h0, 2, 10);
      xfer(1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'h11BB_33DD, 2, 10);

      // Top word of the window and an untouched word
      xfer(1'b1, 32'h0000_07FC, 4'hF, 32'hA5A5_0F0F, 32'h0, 2, 10);
      xfer(1'b0, 32'h0000_07FC, 4'hF, 32'h0, 32'hA5A5_0F0F, 2, 10);
      xfer(1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'h0, 2, 10);

      // Address outside the window is ignored
      @(negedge CLK);
      drive(1'b1, 32'h0000_0800, 4'hF, 32'h1234_5678);
      cen_lows = 0;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (!ram_cen) cen_lows++;
         if (wb_ack_o) acks++;
      end
      idle_bus();
      chk("nomatch_cen_pulses", 32'(cen_lows), 32'h0);
      chk("nomatch_acks", 32'(acks), 32'h0);
      xfer(1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'h0, 2, 10);

      // Cycle dropped during ACCESS: write commits, no ack, next request taken at once
      @(negedge CLK);
      drive(1'b1, 32'h0000_0020, 4'hF, 32'h5A5A_5A5A);
      @(negedge CLK);
      idle_bus();
      xfer(1'b0, 32'h0000_0020, 4'hF, 32'h0, 32'h5A5A_5A5A, 2, 10);

      // Reset during ACCESS aborts the write
      xfer(1'b1, 32'h0000_0030, 4'hF, 32'h1234_5678, 32'h0, 2, 10);
      @(negedge CLK);
      drive(1'b1, 32'h0000_0030, 4'hF, 32'hFFFF_FFFF);
      @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk("rst_abort_cen", {31'h0, ram_cen}, 32'h1);
      chk("rst_abort_ack", {31'h0, wb_ack_o}, 32'h0);
      idle_bus();
      @(negedge CLK);
      RST = 1'b0;
`ifdef WB_SRAM_INIT_CLEAR_EN
      wait_done(n);
      chk("init_time_2", 32'(n), 32'd512);
      exp_30 = 32'h0;
`else
      exp_30 = 32'h1234_5678;
`endif
      xfer(1'b0, 32'h0000_0030, 4'hF, 32'h0, exp_30, 2, 10);

`ifdef WB_SRAM_INIT_CLEAR_EN
      // Request issued during CLEAR stalls until done, and sees the cleared word
      xfer(1'b1, 32'h0000_001C, 4'hF, 32'hCAFE_F00D, 32'h0, 2, 10);
      xfer(1'b0, 32'h0000_001C, 4'hF, 32'h0, 32'hCAFE_F00D, 2, 10);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      xfer(1'b0, 32'h0000_001C, 4'hF, 32'h0, 32'h0, 513, 700);
      chk("clear_done_after", {31'h0, init_done_o}, 32'h1);
`endif

      repeat (4) @(negedge CLK);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/wb_sram_512x32_ctrl.md
WB_SRAM_512X32_CTRL -- requirements
Module: wb_sram_512x32_ctrl

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_0000, byte base address; only bits [31:11] are compared.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone classic cycle, strobe, write.
REQ-005 wb_sel_i  input  4  byte selects; bit n selects D[8n+7:8n].
REQ-006 wb_adr_i  input  32  byte address; word index = [10:2]; [1:0] ignored.
REQ-007 wb_dat_i  input  32  write data.
REQ-008 wb_dat_o  output  32  read data.
REQ-009 wb_ack_o  output  1  single-cycle transfer acknowledge.
REQ-010 ram_cen, ram_gwen  output  1 each  SRAM chip enable and global write enable, active-low.
REQ-011 ram_wen  output  4  SRAM byte write enables, active-low.
REQ-012 ram_a  output  9  SRAM word address.
REQ-013 ram_d  output  32  SRAM write data.
REQ-014 ram_q  input  32  SRAM read data, valid the cycle after the sampling edge.
REQ-015 init_done_o  output  1  high when bus accesses are accepted.

Function
REQ-016 Request = wb_cyc_i & wb_stb_i & (wb_adr_i[31:11] == BASE_ADDR[31:11]); non-matching requests are ignored and never acked.
REQ-017 States: CLEAR (macro only), IDLE, ACCESS, ACK.
REQ-018 IDLE: on request at an edge -> ACCESS; the same edge registers ram_a=adr[10:2], ram_d=wb_dat_i, ram_cen=0, ram_gwen=~wb_we_i, ram_wen=wb_we_i ? ~wb_sel_i : 4'hF.
REQ-019 ACCESS: the SRAM samples at this edge; the controller registers ram_cen=1, ram_gwen=1, ram_wen=4'hF and wb_ack_o=wb_cyc_i, then -> ACK.
REQ-020 ACK: wb_ack_o high for exactly this cycle; wb_dat_o = ram_q on an acked read, otherwise 32'h0; next edge -> IDLE with wb_ack_o=0.
REQ-021 Latency: ack is high during the third cycle after the request is first sampled; minimum 3 cycles per transfer; no pipelining.
REQ-022 Write with wb_sel_i=4'h0: GWEN pulses low with WEN=4'hF, no byte changes, ack still given.
REQ-023 wb_cyc_i dropped during ACCESS: the SRAM access still completes (writes commit), ack is suppressed, and the FSM returns to IDLE.
REQ-024 Inputs are not required to be held after the IDLE sampling edge; the registered copies are used.

Reset
REQ-025 Asynchronous RST forces: state IDLE (CLEAR with macro), ram_cen=1, ram_gwen=1, ram_wen=4'hF, ram_a=0, ram_d=0, wb_ack_o=0, wb_dat_o=0.
REQ-026 init_done_o reset value: 0 with macro, 1 without; RST during ACCESS aborts the access with no ack, and because CEN is forced high before the next edge no write occurs.

Configuration
REQ-027 Macro WB_SRAM_INIT_CLEAR_EN defined: after reset, CLEAR writes 32'h0 to words 0..511, one per cycle (CEN=0, GWEN=0, WEN=0), using a 9-bit counter.
REQ-028 At counter wrap (511 written): init_done_o=1 -> IDLE; requests during CLEAR stall unacked until then.
REQ-029 Macro undefined: no CLEAR state or counter; init_done_o is constant 1 and the FSM starts in IDLE.

Structure
REQ-030 Package wb_sram_pkg holds the state enum, RAM_AW=9, RAM_DW=32, RAM_BYTES=4 and INIT_LAST=9'd511.
REQ-031 Optional sub-module wb_sram_init_seq holds the clear counter and done flag; it is instantiated only under the macro.

Verification
REQ-032 Write adr 0x0000_0010, sel 4'hF, data 0xDEADBEEF -> ram_a=4, ram_gwen=0, ram_wen=0 for one cycle, ack 3rd cycle; read back -> wb_dat_o=0xDEADBEEF with ack.
REQ-033 Write 0x11223344 (sel F), then write 0xAABBCCDD with sel 4'b0101 at the same address -> read returns 0x11BB33DD.
REQ-034 Request at adr 0x0000_0800 with BASE_ADDR=0 -> no CEN pulse and no ack for 20 cycles.
REQ-035 Drop wb_cyc_i during ACCESS on a write of 0x5A5A5A5A -> no ack, FSM in IDLE next cycle, later read returns 0x5A5A5A5A.
REQ-036 Assert RST in ACCESS of a write -> ram_cen=1 immediately, no ack, word unchanged.
REQ-037 With WB_SRAM_INIT_CLEAR_EN, preload word 7 and apply reset -> init_done_o rises 512 cycles after release, word 7 reads 0, and a request issued during CLEAR is acked only after done.
